burst_read_fsm: RTL and testbench

Parametrised burst read controller; the multi-beat, error-aware successor of the single-beat IDLE/READ/DLY/DONE read handshake. A start pulse with a base address and beat count launches a sequence of read strobes, one per address. Wait-state retries are handled per beat, a retry limit and an external abort both terminate the burst through an error state, and the outputs can be combinational or registered. The block sits between a request source and a slow, wait-stated memory port.

---
 rtl/fsm_pkg.sv | 71 +++++++
 rtl/retry_counter.sv | 29 ++
 rtl/burst_read_fsm.sv | 141 ++++++++++++++
 tb/tb_burst_read_fsm.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared definitions for the burst read controller: state encoding,
// the decoded output bundle and an ASCII state-name helper for waveform debug.
package fsm_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    DLY  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE = IDLE;
  localparam logic [STATE_W-1:0] S_READ = READ;
  localparam logic [STATE_W-1:0] S_DLY  = DLY;
  localparam logic [STATE_W-1:0] S_DONE = DONE;
  localparam logic [STATE_W-1:0] S_ERR  = ERR;

  typedef struct packed {
    logic rd;
    logic ds;
    logic err;
    logic busy;
  } fsm_out_t;

  // Moore decode shared by the combinational and registered output paths.
  function automatic fsm_out_t decode_outputs(input logic [STATE_W-1:0] s);
    fsm_out_t o;
    o = '0;
    case (s)
      S_IDLE: o = '0;
      S_READ,
      S_DLY: begin
        o.rd   = 1'b1;
        o.busy = 1'b1;
      end
      S_DONE: begin
        o.ds   = 1'b1;
        o.busy = 1'b1;
      end
      S_ERR: begin
        o.err  = 1'b1;
        o.busy = 1'b1;
      end
      default: begin
`ifdef SYNTHESIS
        o = '0;
`else
        o = 'x;
`endif
      end
    endcase
    return o;
  endfunction

  function automatic logic [31:0] state_name(input logic [STATE_W-1:0] s);
    logic [31:0] n;
    case (s)
      S_IDLE:  n = "IDLE";
      S_READ:  n = "READ";
      S_DLY:   n = "DLY ";
      S_DONE:  n = "DONE";
      S_ERR:   n = "ERR ";
      default: n = "????";
    endcase
    return n;
  endfunction

endpackage

// File: rtl/retry_counter.sv
// Per-beat wait-state retry counter: saturates at MAX_RETRY and flags the limit.
module retry_counter #(
  parameter int MAX_RETRY = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int CW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_RETRY);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/burst_read_fsm.sv
// Multi-beat read controller with per-beat wait-state retries, retry limit
// and abort, driving a slow memory port one address per beat.
module burst_read_fsm
  import fsm_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int LEN_W     = 4,
  parameter int MAX_RETRY = 3,
  parameter int OUT_REG   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              ws,
  input  logic              abort,
  output logic              rd,
  output logic              ds,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic [LEN_W-1:0]  beat_cnt
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_n;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   beat_cnt_q;
  logic [LEN_W-1:0]   remain;
  logic               accept;
  logic               beat_ok;
  logic               retry_inc;
  logic               retry_at_limit;
  logic               last_beat;
  fsm_out_t           outs;

  assign last_beat = (remain == LEN_W'(1));

  retry_counter #(
    .MAX_RETRY (MAX_RETRY)
  ) u_retry (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept | beat_ok),
    .inc      (retry_inc),
    .at_limit (retry_at_limit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      remain     <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q     <= base_addr;
        remain     <= len;
        beat_cnt_q <= '0;
      end else if (beat_ok) begin
        beat_cnt_q <= beat_cnt_q + LEN_W'(1);
        remain     <= remain - LEN_W'(1);
        // Address stays on the last beat so it is still visible after DONE.
        if (!last_beat) begin
          addr_q <= addr_q + ADDR_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    beat_ok   = 1'b0;
    retry_inc = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && (len != '0)) begin
          accept  = 1'b1;
          state_n = S_READ;
        end
      end
      S_READ: begin
        state_n = abort ? S_ERR : S_DLY;
      end
      S_DLY: begin
        if (abort) begin
          state_n = S_ERR;
        end else if (ws) begin
          if (retry_at_limit) begin
            state_n = S_ERR;
          end else begin
            retry_inc = 1'b1;
            state_n   = S_READ;
          end
        end else begin
          beat_ok = 1'b1;
          state_n = last_beat ? S_DONE : S_READ;
        end
      end
      S_DONE,
      S_ERR: begin
        state_n = S_IDLE;
      end
      default: begin
`ifdef SYNTHESIS
        state_n = S_IDLE;
`else
        state_n = 'x;
`endif
      end
    endcase
  end

  // Registered mode decodes the next state so pins change on the same edge as state.
  generate
    if (OUT_REG != 0) begin : g_out_reg
      fsm_out_t outs_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          outs_q <= '0;
        end else begin
          outs_q <= decode_outputs(state_n);
        end
      end
      assign outs = outs_q;
    end else begin : g_out_comb
      assign outs = decode_outputs(state);
    end
  endgenerate

  assign rd       = outs.rd;
  assign ds       = outs.ds;
  assign err      = outs.err;
  assign busy     = outs.busy;
  assign addr     = addr_q;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_burst_read_fsm.sv
// Scoreboarded bench: both output modes run side by side on identical stimulus
// and every cycle of each is compared against a spec-derived expected trace.
module tb_burst_read_fsm;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [3:0] len;
  logic       ws;
  logic       abort;

  logic       rd_o   [2];
  logic       ds_o   [2];
  logic       err_o  [2];
  logic       busy_o [2];
  logic [7:0] addr_o [2];
  logic [3:0] bc_o   [2];

  // record = {rd, ds, err, busy, addr[7:0], beat_cnt[3:0]}
  localparam logic [3:0] O_IDLE = 4'b0000;
  localparam logic [3:0] O_RD   = 4'b1001;
  localparam logic [3:0] O_DS   = 4'b0101;
  localparam logic [3:0] O_ERR  = 4'b0011;

  logic [15:0] sb [$];
  int          errors;
  int          checks;
  int          cyc;
  logic        mon_en;
  string       tag;

  burst_read_fsm #(.ADDR_W(8), .LEN_W(4), .MAX_RETRY(3), .OUT_REG(0)) dut_comb (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .ws(ws), .abort(abort), .rd(rd_o[0]), .ds(ds_o[0]), .err(err_o[0]),
    .busy(busy_o[0]), .addr(addr_o[0]), .beat_cnt(bc_o[0])
  );

  burst_read_fsm #(.ADDR_W(8), .LEN_W(4), .MAX_RETRY(3), .OUT_REG(1)) dut_reg (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .ws(ws), .abort(abort), .rd(rd_o[1]), .ds(ds_o[1]), .err(err_o[1]),
    .busy(busy_o[1]), .addr(addr_o[1]), .beat_cnt(bc_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic ex(input logic [3:0] o, input logic [7:0] a, input logic [3:0] b);
    sb.push_back({o, a, b});
  endtask

  task automatic ex_pairs(input logic [7:0] a, input logic [3:0] b, input int p);
    repeat (2 * p) ex(O_RD, a, b);
  endtask

  task automatic drive(input int n, input logic [7:0] ba, input logic [3:0] ln,
                       input logic [15:0] st_m, input logic [15:0] ws_m,
                       input logic [15:0] ab_m);
    cyc    = 0;
    mon_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start     = st_m[k];
      ws        = ws_m[k];
      abort     = ab_m[k];
      base_addr = ba;
      len       = ln;
    end
    #1;
    mon_en = 1'b0;
    start  = 1'b0;
    ws     = 1'b0;
    abort  = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s leftover: %0d records unconsumed, expected 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rd_o[d], ds_o[d], err_o[d], busy_o[d], addr_o[d], bc_o[d]} !== 16'h0000) begin
        errors++;
        $display("FAIL reset dut%0d: got %h expected 0000", d,
                 {rd_o[d], ds_o[d], err_o[d], busy_o[d], addr_o[d], bc_o[d]});
      end
    end
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single_beat;
    tag = "single_beat";
    ex(O_IDLE, 8'h00, 4'd0);
    ex_pairs(8'h10, 4'd0, 1);
    ex(O_DS, 8'h10, 4'd1);
    ex(O_IDLE, 8'h10, 4'd1);
    drive(5, 8'h10, 4'd1, 16'h0001, 16'h0000, 16'h0000);
  endtask

  task automatic test_wrap;
    tag = "wrap";
    ex(O_IDLE, 8'h10, 4'd1);
    ex_pairs(8'hFE, 4'd0, 1);
    ex_pairs(8'hFF, 4'd1, 1);
    ex_pairs(8'h00, 4'd2, 1);
    ex(O_DS, 8'h00, 4'd3);
    ex(O_IDLE, 8'h00, 4'd3);
    drive(9, 8'hFE, 4'd3, 16'h0001, 16'h0000, 16'h0000);
  endtask

  task automatic test_retries;
    tag = "retries";
    ex(O_IDLE, 8'h00, 4'd3);
    ex_pairs(8'h20, 4'd0, 3);
    ex_pairs(8'h21, 4'd1, 1);
    ex(O_DS, 8'h21, 4'd2);
    ex(O_IDLE, 8'h21, 4'd2);
    drive(11, 8'h20, 4'd2, 16'h0001, 16'h0014, 16'h0000);
  endtask

  task automatic test_retry_boundary;
    tag = "retry_boundary";
    ex(O_IDLE, 8'h21, 4'd2);
    ex_pairs(8'h80, 4'd0, 4);
    ex(O_DS, 8'h80, 4'd1);
    ex(O_IDLE, 8'h80, 4'd1);
    drive(11, 8'h80, 4'd1, 16'h0001, 16'h0054, 16'h0000);
  endtask

  task automatic test_retry_limit;
    tag = "retry_limit";
    ex(O_IDLE, 8'h80, 4'd1);
    ex_pairs(8'h30, 4'd0, 4);
    ex(O_ERR, 8'h30, 4'd0);
    ex(O_IDLE, 8'h30, 4'd0);
    drive(11, 8'h30, 4'd2, 16'h0001, 16'hFFFF, 16'h0000);
  endtask

  task automatic test_abort;
    tag = "abort";
    ex(O_IDLE, 8'h30, 4'd0);
    ex_pairs(8'h40, 4'd0, 1);
    ex(O_RD, 8'h41, 4'd1);
    ex(O_ERR, 8'h41, 4'd1);
    ex(O_IDLE, 8'h41, 4'd1);
    drive(6, 8'h40, 4'd4, 16'h0001, 16'h0000, 16'h0008);
  endtask

  task automatic test_len_zero;
    tag = "len_zero";
    repeat (4) ex(O_IDLE, 8'h41, 4'd1);
    drive(4, 8'h55, 4'd0, 16'h000F, 16'h0000, 16'h0000);
  endtask

  task automatic test_back_to_back;
    tag = "back_to_back";
    ex(O_IDLE, 8'h41, 4'd1);
    ex_pairs(8'h60, 4'd0, 1);
    ex(O_DS, 8'h60, 4'd1);
    ex(O_IDLE, 8'h60, 4'd1);
    ex_pairs(8'h60, 4'd0, 1);
    ex(O_DS, 8'h60, 4'd1);
    ex(O_IDLE, 8'h60, 4'd1);
    // start also high during DONE (k3), which must not launch a burst
    drive(9, 8'h60, 4'd1, 16'h0019, 16'h0000, 16'h0000);
  endtask

  task automatic test_reset_mid_burst;
    tag = "reset_mid";
    ex(O_IDLE, 8'h60, 4'd1);
    ex_pairs(8'h70, 4'd0, 1);
    ex(O_IDLE, 8'h00, 4'd0);
    ex(O_IDLE, 8'h00, 4'd0);
    cyc       = 0;
    base_addr = 8'h70;
    len       = 4'd2;
    mon_en    = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rd_o[d], ds_o[d], err_o[d], busy_o[d], addr_o[d], bc_o[d]} !== 16'h0000) begin
        errors++;
        $display("FAIL reset_mid async dut%0d: got %h expected 0000", d,
                 {rd_o[d], ds_o[d], err_o[d], busy_o[d], addr_o[d], bc_o[d]});
      end
    end
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1 mon_en = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reset_mid leftover: %0d records unconsumed, expected 0", sb.size());
      sb.delete();
    end
    tag = "after_reset";
    ex(O_IDLE, 8'h00, 4'd0);
    ex_pairs(8'hC3, 4'd0, 1);
    ex(O_DS, 8'hC3, 4'd1);
    ex(O_IDLE, 8'hC3, 4'd1);
    drive(5, 8'hC3, 4'd1, 16'h0001, 16'h0000, 16'h0000);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    cyc       = 0;
    mon_en    = 1'b0;
    tag       = "init";
    start     = 1'b0;
    base_addr = 8'h00;
    len       = 4'd0;
    ws        = 1'b0;
    abort     = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s underflow cycle %0d: got output with no expected record", tag, cyc);
          end else begin
            logic [15:0] e;
            logic [15:0] got;
            e = sb.pop_front();
            for (int d = 0; d < 2; d++) begin
              got = {rd_o[d], ds_o[d], err_o[d], busy_o[d], addr_o[d], bc_o[d]};
              checks++;
              if (got !== e) begin
                errors++;
                $display("FAIL %s dut%0d cycle %0d: got rd/ds/err/busy=%b addr=%h beat_cnt=%0d, expected rd/ds/err/busy=%b addr=%h beat_cnt=%0d",
                         tag, d, cyc, got[15:12], got[11:4], got[3:0], e[15:12], e[11:4], e[3:0]);
              end
            end
          end
          cyc++;
        end
      end
    join_none

    test_reset();
    test_single_beat();
    test_wrap();
    test_retries();
    test_retry_boundary();
    test_retry_limit();
    test_abort();
    test_len_zero();
    test_back_to_back();
    test_reset_mid_burst();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
